// File: rtl/csr_pkg.sv
// Shared types, constants and decode helpers for the Zicsr execution unit.
package csr_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned OPW  = 3;
  localparam int unsigned IDXW = 5;
  localparam int unsigned CW   = 64;

  // Low two bits of funct3 select the operation; bit 2 selects the zimm operand.
  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_RW   = 2'b01;
  localparam logic [1:0] KIND_RS   = 2'b10;
  localparam logic [1:0] KIND_RC   = 2'b11;

  localparam logic [AW-1:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [AW-1:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [AW-1:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [AW-1:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [AW-1:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [AW-1:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [AW-1:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [AW-1:0] ADDR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_e;

  typedef struct packed {
    logic [1:0]      kind;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] operand;
    logic            we_en;
    logic            illegal;
    logic            counter;
  } req_t;

  function automatic logic is_read_only(input logic [AW-1:0] addr);
    return addr[AW-1 -: 2] == 2'b11;
  endfunction

  function automatic logic is_counter(input logic [AW-1:0] addr);
    case (addr)
      ADDR_CYCLE, ADDR_CYCLEH, ADDR_INSTRET, ADDR_INSTRETH,
      ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Set/clear forms only write when rs1/zimm field is non-zero.
  function automatic req_t decode(input logic [OPW-1:0]  op,
                                  input logic [AW-1:0]   addr,
                                  input logic [XLEN-1:0] rs1_data,
                                  input logic [IDXW-1:0] rs1_idx);
    req_t r;
    r.kind    = op[1:0];
    r.addr    = addr;
    r.operand = op[2] ? XLEN'(rs1_idx) : rs1_data;
    r.we_en   = (op[1:0] == KIND_RW) || (rs1_idx != '0);
    r.illegal = (op[1:0] == KIND_NONE) || (r.we_en && is_read_only(addr));
    r.counter = is_counter(addr);
    return r;
  endfunction

endpackage

// File: rtl/csr_if.sv
// Controller <-> CSR unit request/response handshake bundle.
interface csr_if;
  import csr_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [OPW-1:0]  req_op;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_rs1_data;
  logic [IDXW-1:0] req_rs1_idx;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_rs1_data, req_rs1_idx, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_rs1_data, req_rs1_idx, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_illegal
  );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently loadable 32-bit halves.
module csr_counter64
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load_lo,
  input  logic            load_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [CW-1:0]   count
);

  // A load takes priority and suppresses that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load_lo) begin
      count[XLEN-1:0] <= wdata;
    end else if (load_hi) begin
      count[CW-1:XLEN] <= wdata;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Zicsr read-modify-write sequencer between the controller and the CSR file;
// serves cycle/instret from local 64-bit counters.
module csr_unit
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  csr_if.slave            bus,
  input  logic            instret_inc,
  output logic            csr_we,
  output logic [AW-1:0]   csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata
);

  state_e          state;
  req_t            req;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] old_c;
  logic [XLEN-1:0] new_c;
  logic [CW-1:0]   cycle;
  logic [CW-1:0]   instret;
  logic            cnt_wr_c;

  assign bus.req_ready = (state == ST_IDLE);
  assign csr_addr      = req.addr;
  assign csr_wdata     = new_c;
  assign cnt_wr_c      = (state == ST_WRITE) && req.we_en && !req.illegal;

  // Counter addresses are answered locally instead of from the file.
  always_comb begin
    old_c = csr_rdata;
    case (req.addr)
      ADDR_CYCLE,    ADDR_MCYCLE:    old_c = cycle[XLEN-1:0];
      ADDR_CYCLEH,   ADDR_MCYCLEH:   old_c = cycle[CW-1:XLEN];
      ADDR_INSTRET,  ADDR_MINSTRET:  old_c = instret[XLEN-1:0];
      ADDR_INSTRETH, ADDR_MINSTRETH: old_c = instret[CW-1:XLEN];
      default: ;
    endcase
  end

  always_comb begin
    new_c = req.operand;
    case (req.kind)
      KIND_RS: new_c = old_q | req.operand;
      KIND_RC: new_c = old_q & ~req.operand;
      default: ;
    endcase
  end

  csr_counter64 u_cycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .load_lo (cnt_wr_c && (req.addr == ADDR_MCYCLE)),
    .load_hi (cnt_wr_c && (req.addr == ADDR_MCYCLEH)),
    .wdata   (new_c),
    .count   (cycle)
  );

  csr_counter64 u_instret (
    .clk     (clk),
    .rst     (rst),
    .inc     (instret_inc),
    .load_lo (cnt_wr_c && (req.addr == ADDR_MINSTRET)),
    .load_hi (cnt_wr_c && (req.addr == ADDR_MINSTRETH)),
    .wdata   (new_c),
    .count   (instret)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      req              <= '0;
      old_q            <= '0;
      csr_we           <= 1'b0;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.resp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req   <= decode(bus.req_op, bus.req_addr, bus.req_rs1_data, bus.req_rs1_idx);
            state <= ST_READ;
          end
        end
        ST_READ: begin
          old_q  <= old_c;
          csr_we <= req.we_en && !req.illegal && !req.counter;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          csr_we           <= 1'b0;
          bus.resp_valid   <= 1'b1;
          bus.resp_rdata   <= req.illegal ? '0 : old_q;
          bus.resp_illegal <= req.illegal;
          state            <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: reference model of the CSR file and counters,
// expected responses/writes queued at issue and checked by a separate monitor.
module tb_csr_unit;
  import csr_pkg::*;

  typedef struct { logic [31:0] rdata; logic illegal; int at; } resp_exp_t;
  typedef struct { logic [11:0] addr; logic [31:0] data; int at; } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instret_inc = 1'b0;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  csr_if bus();

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  logic [31:0] file_mem [4096];
  logic [31:0] ref_file [4096];
  resp_exp_t   rq[$];
  wr_exp_t     wq[$];

  logic [63:0] m_cyc = '0;
  logic [63:0] m_ins = '0;
  bit          ld_pend = 1'b0;
  bit          ld_ins = 1'b0;
  bit          ld_hi = 1'b0;
  int          ld_at = 0;
  logic [31:0] ld_val = '0;
  bit          hold_ready = 1'b0;
  bit          force_inc = 1'b0;
  bit          seen = 1'b0;

  csr_unit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .instret_inc (instret_inc),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic logic [31:0] seed_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at edge %0d", name, edge_no);
  endtask

  // CSR file seen by the DUT: combinational read, written while csr_we is high.
  assign csr_rdata = file_mem[csr_addr];
  initial begin
    for (int i = 0; i < 4096; i++) file_mem[i] = seed_val(i);
    forever begin
      @(negedge clk);
      if (csr_we === 1'b1) file_mem[csr_addr] = csr_wdata;
    end
  end

  // Monitor: pops expected writes and responses as the DUT presents them.
  always @(negedge clk) begin
    wr_exp_t   w;
    resp_exp_t r;
    if (csr_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_csr_we actual addr=%h data=%h required none", csr_addr, csr_wdata);
      end else begin
        w = wq.pop_front();
        chk("we_addr", 64'(csr_addr), 64'(w.addr));
        chk("we_data", 64'(csr_wdata), 64'(w.data));
        chk("we_cycle", 64'(edge_no), 64'(w.at));
      end
    end
    if (rst === 1'b1) begin
      seen = 1'b0;
    end else if (bus.resp_valid === 1'b1) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual rdata=%h required none", bus.resp_rdata);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("resp_latency", 64'(edge_no), 64'(rq[0].at));
        end
        if (bus.resp_ready === 1'b1) begin
          r = rq.pop_front();
          chk("resp_rdata", 64'(bus.resp_rdata), 64'(r.rdata));
          chk("resp_illegal", 64'(bus.resp_illegal), 64'(r.illegal));
          seen = 1'b0;
        end
      end
    end
  end

  // One clock: advance the counter model by the spec's rules, then drive new random inputs.
  task automatic tick();
    logic inc_now;
    logic rst_now;
    logic ld_here;
    inc_now = instret_inc;
    rst_now = rst;
    @(posedge clk);
    #1;
    if (rst_now) begin
      m_cyc   = '0;
      m_ins   = '0;
      ld_pend = 1'b0;
    end else begin
      ld_here = ld_pend && (ld_at == edge_no);
      if (ld_here && !ld_ins) begin
        if (ld_hi) m_cyc[63:32] = ld_val; else m_cyc[31:0] = ld_val;
      end else begin
        m_cyc = m_cyc + 64'd1;
      end
      if (ld_here && ld_ins) begin
        if (ld_hi) m_ins[63:32] = ld_val; else m_ins[31:0] = ld_val;
      end else if (inc_now) begin
        m_ins = m_ins + 64'd1;
      end
      if (ld_here) ld_pend = 1'b0;
    end
    bus.resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    instret_inc    = force_inc ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((bus.req_ready !== 1'b1 || rq.size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) fail_now("wait_idle");
  endtask

  task automatic do_req(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] d, input logic [4:0] idx);
    int          guard;
    int          e;
    logic [31:0] operand;
    logic [31:0] old;
    logic [31:0] nv;
    logic        we_en;
    logic        ill;
    logic        cnt;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      fail_now("req_accept");
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_addr     = addr;
    bus.req_rs1_data = d;
    bus.req_rs1_idx  = idx;
    tick();
    e = edge_no;
    bus.req_valid    = 1'b0;
    bus.req_op       = 3'($urandom);
    bus.req_addr     = 12'($urandom);
    bus.req_rs1_data = $urandom;
    bus.req_rs1_idx  = 5'($urandom);

    operand = op[2] ? {27'b0, idx} : d;
    we_en   = (op[1:0] == 2'b01) || (idx != 5'd0);
    ill     = (op[1:0] == 2'b00) || (we_en && addr[11:10] == 2'b11);
    cnt     = 1'b1;
    case (addr)
      12'hC00, 12'hB00: old = m_cyc[31:0];
      12'hC80, 12'hB80: old = m_cyc[63:32];
      12'hC02, 12'hB02: old = m_ins[31:0];
      12'hC82, 12'hB82: old = m_ins[63:32];
      default: begin old = ref_file[addr]; cnt = 1'b0; end
    endcase
    case (op[1:0])
      2'b10:   nv = old | operand;
      2'b11:   nv = old & ~operand;
      default: nv = operand;
    endcase
    rq.push_back('{rdata: (ill ? 32'h0 : old), illegal: ill, at: e + 2});
    if (!ill && we_en) begin
      if (cnt) begin
        ld_pend = 1'b1;
        ld_at   = e + 2;
        ld_ins  = addr[1];
        ld_hi   = addr[7];
        ld_val  = nv;
      end else begin
        wq.push_back('{addr: addr, data: nv, at: e + 1});
        ref_file[addr] = nv;
      end
    end
  endtask

  initial begin
    logic [11:0] pool [15];
    logic [2:0]  op;
    logic [4:0]  idx;
    int          guard;

    pool = '{12'h340, 12'h300, 12'h305, 12'h341, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
             12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC01, 12'hF11, 12'h7C0};
    for (int i = 0; i < 4096; i++) ref_file[i] = seed_val(i);
    bus.req_valid    = 1'b0;
    bus.req_op       = '0;
    bus.req_addr     = '0;
    bus.req_rs1_data = '0;
    bus.req_rs1_idx  = '0;
    bus.resp_ready   = 1'b0;

    repeat (3) tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("rst_resp_illegal", 64'(bus.resp_illegal), 64'd0);
    chk("rst_csr_we", 64'(csr_we), 64'd0);
    chk("rst_csr_addr", 64'(csr_addr), 64'd0);
    chk("rst_csr_wdata", 64'(csr_wdata), 64'd0);
    rst = 1'b0;

    // Directed cases from the plan.
    do_req(3'b001, 12'h340, 32'h0000_1234, 5'd1);
    do_req(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5);
    do_req(3'b001, 12'h300, 32'h0000_0008, 5'd2);
    do_req(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0);
    do_req(3'b111, 12'h300, 32'h0, 5'd8);
    do_req(3'b001, 12'hC00, 32'h1111_2222, 5'd3);
    do_req(3'b010, 12'hC00, 32'h0, 5'd0);
    do_req(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd1);
    do_req(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1);
    do_req(3'b010, 12'hC80, 32'h0, 5'd0);
    do_req(3'b010, 12'hC00, 32'h0, 5'd0);

    wait_idle();
    force_inc = 1'b1;
    do_req(3'b001, 12'hB02, 32'h5, 5'd1);
    repeat (3) tick();
    force_inc = 1'b0;
    do_req(3'b010, 12'hC02, 32'h0, 5'd0);
    do_req(3'b010, 12'hC82, 32'h0, 5'd0);

    for (int n = 0; n < 150; n++) begin
      op  = 3'($urandom_range(0, 7));
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_req(op, pool[$urandom_range(0, 14)], $urandom, idx);
    end

    // Reset while the write is in flight and the controller is stalling.
    wait_idle();
    hold_ready = 1'b1;
    do_req(3'b001, 12'h341, 32'hCAFE_F00D, 5'd3);
    tick();
    rst = 1'b1;
    tick();
    rq.delete();
    chk("midrst_csr_we", 64'(csr_we), 64'd0);
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    rst = 1'b0;
    hold_ready = 1'b0;
    do_req(3'b010, 12'hC00, 32'h0, 5'd0);
    do_req(3'b010, 12'hC82, 32'h0, 5'd0);
    do_req(3'b100, 12'h340, 32'h1234_5678, 5'd3);

    guard = 0;
    while ((rq.size() != 0 || wq.size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) fail_now("drain");
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Sequential execution unit for the Zicsr instructions (CSRRW/S/C and the immediate forms), sitting between the controller and the CSR file. Accepts one decoded CSR request at a time, reads the old value, computes the read-modify-write result, and drives the CSR file's write port. It answers the cycle/instret counter CSRs from its own 64-bit counters instead of from the file, and returns the old value plus an illegal flag to the controller.

## Interface
- No parameters; data width fixed at 32, CSR address width 12.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  controller presents a CSR request
- req_ready  out  1  unit can accept (high only in IDLE)
- req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_addr  in  12  CSR address
- req_rs1_data  in  32  rs1 operand (register forms)
- req_rs1_idx  in  5  rs1 field; zimm for immediate forms, zero-extended to 32
- resp_valid  out  1  result available
- resp_ready  in  1  controller consumes result
- resp_rdata  out  32  old CSR value (0 when illegal)
- resp_illegal  out  1  illegal-instruction indication
- instret_inc  in  1  one instruction retired this cycle
- csr_we  out  1  CSR file write enable
- csr_addr  out  12  CSR file address
- csr_wdata  out  32  CSR file write data
- csr_rdata  in  32  CSR file read data, combinational from csr_addr

## Operation
- States: IDLE, READ, WRITE, RESP. Reset → IDLE.
- IDLE: req_ready=1; on req_valid latch op/addr/operand → READ.
- READ: csr_addr=latched addr; capture old value (csr_rdata, or counter for counter addresses) → WRITE.
- WRITE: compute new = operand (RW), old|operand (RS), old&~operand (RC). Assert csr_we for exactly this cycle if write-enabled, legal, and not a counter address → RESP.
- RESP: resp_valid=1, resp_rdata/resp_illegal held stable until resp_ready; on resp_valid&resp_ready → IDLE.
- Write-enabled: RW/RWI always; RS/RC/RSI/RCI only when req_rs1_idx≠0.
- Illegal: op 000 or 100; or write-enabled with addr[11:10]=11 (read-only space). Illegal → no csr_we, no counter write, resp_rdata=0.
- Counters: cycle (+1 every cycle), instret (+1 when instret_inc). Read: 0xC00/0xB00 cycle[31:0], 0xC80/0xB80 cycle[63:32], 0xC02/0xB02 instret[31:0], 0xC82/0xB82 instret[63:32]. Writable only via 0xB00/0xB80/0xB02/0xB82, in WRITE state.
- Counter write loads the selected half; the increment is suppressed for that counter that cycle (write wins over instret_inc/cycle tick).
- 32-bit arithmetic; 64-bit counters wrap 0xFFFF_FFFF_FFFF_FFFF → 0.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, csr_we=0, csr_addr=0, csr_wdata=0, counters=0.
- Accept at edge T; READ T+1; csr_we high during T+2 (file updated at end of T+2); resp_valid from T+3.
- Minimum 4 cycles per request; next accept no earlier than cycle after resp handshake.
- All outputs registered except req_ready (decoded from state) and csr_addr/csr_wdata (from latched request).
- rst mid-operation: immediate return to IDLE, pending write abandoned (no csr_we), counters cleared.
- req_valid while not IDLE is ignored; inputs need not be held after acceptance.

## Structure
- Package csr_pkg: op encodings, state enum, counter address constants, read-only-space test function.
- Sub-module csr_counter64: 64-bit counter with inc, load_lo, load_hi, 32-bit wdata; instantiated twice (cycle, instret).

## Test plan
- CSRRW 0x340, rs1=0xDEAD_BEEF, file holds 0x1234 → resp_rdata=0x1234, csr_we one cycle with wdata 0xDEAD_BEEF, resp_valid at T+3.
- CSRRS 0x300, rs1_idx=0, file 0x8 → resp_rdata=0x8, csr_we never asserted; CSRRCI zimm=0x8 → wdata 0x0.
- CSRRW to 0xC00 → resp_illegal=1, resp_rdata=0, no csr_we; CSRRS 0xC00 with rs1_idx=0 → legal, rdata = cycle value.
- Write 0xFFFF_FFFF to 0xB00 and 0xB80 → cycle wraps to 0 two cycles later; no csr_we issued.
- CSRRW minstret (0xB02)=5 with instret_inc high same WRITE cycle → instret=5, then 6 on next pulse.
- rst asserted in WRITE with resp_ready=0 → csr_we=0, resp_valid=0, req_ready=1 next cycle; op 100 → illegal.
